// File: rtl/fcp_pkg.sv
// Shared encodings for the FCP output-voltage sequencer: level codes, state
// encoding and the request-level encoding used by fcp_core.
package fcp_pkg;

    localparam logic [7:0] CODE_5V  = 8'd50;
    localparam logic [7:0] CODE_9V  = 8'd90;
    localparam logic [7:0] CODE_12V = 8'd120;

    localparam logic [1:0] LVL_5V   = 2'b00;
    localparam logic [1:0] LVL_9V   = 2'b01;
    localparam logic [1:0] LVL_12V  = 2'b10;
    localparam logic [1:0] LVL_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RAMP_UP = 3'd1;
    localparam logic [2:0] ST_RAMP_DN = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    function automatic logic [7:0] lvl_to_code(input logic [1:0] lvl);
        case (lvl)
            LVL_9V:  return CODE_9V;
            LVL_12V: return CODE_12V;
            default: return CODE_5V;
        endcase
    endfunction

endpackage

// File: rtl/fcp_tick_timer.sv
// 16-bit loadable down-counter; o_done flags the last enabled cycle of a count.
module fcp_tick_timer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic        o_done
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != 16'd0)) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_done = i_en && (r_cnt == 16'd1);

endmodule

// File: rtl/fcp_volt_seq.sv
// FCP VBUS setpoint sequencer: ramps the regulator code one step at a time toward
// the requested level, checks settling, and falls back to 5V on watchdog or master reset.
module fcp_volt_seq
    import fcp_pkg::*;
#(
    parameter int unsigned STEP_CYC   = 16,
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned WDOG_CYC   = 65535
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_volt,
    input  logic       ping_seen,
    input  logic       reset_from_master,
    input  logic       vbus_ok,
    output logic [7:0] vset_code,
    output logic       discharge,
    output logic       volt_stable,
    output logic [1:0] cur_volt,
    output logic       fault,
    output logic       wdog_expired
);

    localparam logic [15:0] STEP_LD   = 16'(STEP_CYC);
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC);
    localparam logic [15:0] WDOG_LD   = 16'(WDOG_CYC);

    logic [2:0] r_state;
    logic [7:0] r_vset;
    logic [7:0] r_target;
    logic [1:0] r_tgt_lvl;
    logic       r_mask;
    logic       r_stable;
    logic [1:0] r_cur;
    logic       r_settle_dn;

    logic       w_in_fault;
    logic       w_ramp;
    logic       w_up;
    logic       w_dn;
    logic       w_move;
    logic [7:0] w_step_val;
    logic       w_step_done;
    logic       w_settle_done;
    logic       w_wdog_done;
    logic       w_wdog_fire;
    logic       w_force5;
    logic       w_enter_fault;
    logic       w_step_load;
    logic       w_settle_load;

    assign w_in_fault    = (r_state == ST_FAULT);
    assign w_ramp        = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DN);
    assign w_up          = (r_target > r_vset);
    assign w_dn          = (r_target < r_vset);
    assign w_move        = w_up || w_dn;
    assign w_step_val    = w_up ? (r_vset + 8'd1) : (r_vset - 8'd1);
    // A ping in the expiry cycle reloads the watchdog and cancels the expiry.
    assign w_wdog_fire   = w_wdog_done && !ping_seen;
    assign w_force5      = (reset_from_master && !w_in_fault) || w_wdog_fire;
    assign w_enter_fault = (r_state == ST_SETTLE) && !w_move && w_settle_done && !vbus_ok;
    assign w_step_load   = (((r_state == ST_IDLE) || (r_state == ST_SETTLE)) && w_move) ||
                           (w_ramp && w_step_done);
    assign w_settle_load = w_ramp && (!w_move || (w_step_done && (w_step_val == r_target)));

    fcp_tick_timer u_step_tmr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_step_load),
        .i_load_val (STEP_LD),
        .i_en       (w_ramp),
        .o_done     (w_step_done)
    );

    fcp_tick_timer u_settle_tmr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_LD),
        .i_en       (r_state == ST_SETTLE),
        .o_done     (w_settle_done)
    );

    fcp_tick_timer u_wdog_tmr (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (ping_seen || (r_target == CODE_5V) || w_in_fault),
        .i_load_val (WDOG_LD),
        .i_en       ((r_target != CODE_5V) && !w_in_fault),
        .o_done     (w_wdog_done)
    );

    // Target selection; the mask holds 5V until the master requests 5V itself.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_target  <= CODE_5V;
            r_tgt_lvl <= LVL_5V;
            r_mask    <= 1'b0;
        end else if (w_in_fault || w_enter_fault) begin
            r_target  <= CODE_5V;
            r_tgt_lvl <= LVL_5V;
            r_mask    <= 1'b0;
        end else if (w_force5) begin
            r_target  <= CODE_5V;
            r_tgt_lvl <= LVL_5V;
            r_mask    <= 1'b1;
        end else if (r_mask) begin
            if (req_volt == LVL_5V) begin
                r_mask <= 1'b0;
            end
        end else if (req_volt != LVL_RSVD) begin
            r_target  <= lvl_to_code(req_volt);
            r_tgt_lvl <= req_volt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_vset      <= CODE_5V;
            r_stable    <= 1'b1;
            r_cur       <= LVL_5V;
            r_settle_dn <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_move) begin
                        r_state  <= w_up ? ST_RAMP_UP : ST_RAMP_DN;
                        r_stable <= 1'b0;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DN: begin
                    if (!w_move) begin
                        r_state     <= ST_SETTLE;
                        r_settle_dn <= (r_state == ST_RAMP_DN);
                    end else if (w_step_done) begin
                        r_vset <= w_step_val;
                        if (w_step_val == r_target) begin
                            r_state     <= ST_SETTLE;
                            r_settle_dn <= w_dn;
                        end else begin
                            r_state <= w_up ? ST_RAMP_UP : ST_RAMP_DN;
                        end
                    end else begin
                        r_state <= w_up ? ST_RAMP_UP : ST_RAMP_DN;
                    end
                end
                ST_SETTLE: begin
                    if (w_move) begin
                        r_state <= w_up ? ST_RAMP_UP : ST_RAMP_DN;
                    end else if (w_settle_done) begin
                        if (vbus_ok) begin
                            r_state  <= ST_IDLE;
                            r_stable <= 1'b1;
                            r_cur    <= r_tgt_lvl;
                        end else begin
                            r_state <= ST_FAULT;
                            r_vset  <= CODE_5V;
                            r_cur   <= LVL_5V;
                        end
                    end
                end
                ST_FAULT: begin
                    if (reset_from_master) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign vset_code    = r_vset;
    assign volt_stable  = r_stable;
    assign cur_volt     = r_cur;
    assign fault        = w_in_fault;
    assign wdog_expired = w_wdog_fire;
    assign discharge    = (r_state == ST_RAMP_DN) || w_in_fault ||
                          ((r_state == ST_SETTLE) && r_settle_dn);

endmodule

// File: tb/tb_fcp_volt_seq.sv
// Self-checking bench for fcp_volt_seq: directed scenarios plus random level requests,
// judged against ramp timing derived from step/settle arithmetic.
module tb_fcp_volt_seq;

    localparam int STEP   = 16;
    localparam int SETTLE = 256;
    localparam int WDOG   = 4000;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [1:0] req_volt = 2'b00;
    logic       ping_main = 1'b0;
    logic       ping_auto = 1'b0;
    logic       rfm = 1'b0;
    logic       vbus_ok = 1'b1;
    logic       ping_seen;
    logic [7:0] vset_code;
    logic       discharge;
    logic       volt_stable;
    logic [1:0] cur_volt;
    logic       fault;
    logic       wdog_expired;

    bit auto_ping = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    int t_fall, t_done, n_steps, n_bad, n_dis_bad, max_code;
    int first_at [0:255];
    int n_pulse, first_pulse;

    assign ping_seen = ping_main | ping_auto;

    always #5 clk = ~clk;

    fcp_volt_seq #(
        .STEP_CYC   (STEP),
        .SETTLE_CYC (SETTLE),
        .WDOG_CYC   (WDOG)
    ) u_dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_volt          (req_volt),
        .ping_seen         (ping_seen),
        .reset_from_master (rfm),
        .vbus_ok           (vbus_ok),
        .vset_code         (vset_code),
        .discharge         (discharge),
        .volt_stable       (volt_stable),
        .cur_volt          (cur_volt),
        .fault             (fault),
        .wdog_expired      (wdog_expired)
    );

    // Keeps the watchdog fed outside the watchdog scenarios.
    initial begin
        forever begin
            repeat (500) @(posedge clk);
            if (auto_ping) begin
                #2 ping_auto = 1'b1;
                @(posedge clk);
                #2 ping_auto = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lvl_code(input logic [1:0] l);
        case (l)
            2'b00:   return 50;
            2'b01:   return 90;
            2'b10:   return 120;
            default: return -1;
        endcase
    endfunction

    task automatic wait_code(input int code, input int budget);
        int n;
        n = 0;
        while (int'(vset_code) != code && n < budget) begin
            tick();
            n++;
        end
        check_eq($sformatf("reach_%0d", code), int'(vset_code), code);
    endtask

    // Applies a request and follows the output until it reports settled again.
    task automatic ramp_track(input logic [1:0] req, input int tgt, input logic pulse_rfm,
                              input int budget);
        int start, prev, cur, k;
        bit dn, fell;
        start = int'(vset_code);
        prev = start;
        dn = (tgt < start);
        t_fall = -1;
        t_done = -1;
        n_steps = 0;
        n_bad = 0;
        n_dis_bad = 0;
        max_code = start;
        for (int i = 0; i < 256; i++) first_at[i] = -1;
        fell = (volt_stable == 1'b0);
        if (fell) t_fall = 0;
        req_volt = req;
        rfm = pulse_rfm;
        k = 0;
        while (k < budget && t_done < 0) begin
            tick();
            k++;
            rfm = 1'b0;
            cur = int'(vset_code);
            if (cur != prev) begin
                n_steps++;
                if (first_at[cur] < 0) first_at[cur] = k;
                if (cur - prev > 1 || prev - cur > 1) n_bad++;
                if ((cur > start && cur > tgt) || (cur < start && cur < tgt)) n_bad++;
            end
            if (cur > max_code) max_code = cur;
            prev = cur;
            if (!fell && !volt_stable) begin
                fell = 1'b1;
                t_fall = k;
            end
            if (fell && volt_stable) t_done = k;
            if (discharge != (fell && dn && t_done < 0)) n_dis_bad++;
        end
        if (t_done < 0) check_eq("settle_seen", int'(volt_stable), 1);
    endtask

    task automatic check_ramp(input string tag, input int start, input int tgt,
                              input logic [1:0] lvl);
        int d, dir;
        dir = (tgt > start) ? 1 : -1;
        d = (tgt > start) ? tgt - start : start - tgt;
        check_eq({tag, "_latency"}, t_fall, 2);
        check_eq({tag, "_first_step"}, first_at[start + dir] - t_fall, STEP);
        check_eq({tag, "_ramp_len"}, first_at[tgt] - t_fall, d * STEP);
        check_eq({tag, "_settle_len"}, t_done - t_fall, d * STEP + SETTLE);
        check_eq({tag, "_steps"}, n_steps, d);
        check_eq({tag, "_monotonic"}, n_bad, 0);
        check_eq({tag, "_discharge"}, n_dis_bad, 0);
        check_eq({tag, "_vset"}, int'(vset_code), tgt);
        check_eq({tag, "_cur_volt"}, int'(cur_volt), int'(lvl));
        check_eq({tag, "_fault"}, int'(fault), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_vset"}, int'(vset_code), 50);
        check_eq({tag, "_stable"}, int'(volt_stable), 1);
        check_eq({tag, "_cur_volt"}, int'(cur_volt), 0);
        check_eq({tag, "_fault"}, int'(fault), 0);
        check_eq({tag, "_discharge"}, int'(discharge), 0);
        check_eq({tag, "_wdog"}, int'(wdog_expired), 0);
    endtask

    initial begin
        logic [1:0] lvl;
        int k, start, tgt;

        #2 rstn = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (3) tick();
        check_eq("idle_vset", int'(vset_code), 50);
        auto_ping = 1'b1;

        // 5V -> 9V timing
        ramp_track(2'b01, 90, 1'b0, 2000);
        check_ramp("up9", 50, 90, 2'b01);

        // 9V -> 12V, then 12V -> 5V with discharge (70 single-code steps)
        ramp_track(2'b10, 120, 1'b0, 3000);
        check_ramp("up12", 90, 120, 2'b10);
        ramp_track(2'b00, 50, 1'b0, 3000);
        check_ramp("dn5", 120, 50, 2'b00);
        check_eq("dn5_idle_discharge", int'(discharge), 0);

        // Retarget 12V -> 9V while passing code 70
        req_volt = 2'b10;
        wait_code(70, 2000);
        ramp_track(2'b01, 90, 1'b0, 2000);
        check_eq("retgt_next_step", first_at[71], STEP);
        check_eq("retgt_max", max_code, 90);
        check_eq("retgt_monotonic", n_bad, 0);
        check_eq("retgt_settle_len", t_done, 20 * STEP + SETTLE);
        check_eq("retgt_vset", int'(vset_code), 90);
        check_eq("retgt_cur_volt", int'(cur_volt), 1);

        // Master reset wins over a same-cycle request for 12V, then masks it
        ramp_track(2'b10, 50, 1'b1, 2000);
        check_ramp("rfm", 90, 50, 2'b00);
        repeat (40) tick();
        check_eq("rfm_mask_vset", int'(vset_code), 50);
        check_eq("rfm_mask_stable", int'(volt_stable), 1);
        req_volt = 2'b00;
        repeat (3) tick();
        ramp_track(2'b01, 90, 1'b0, 2000);
        check_ramp("unmask", 50, 90, 2'b01);
        ramp_track(2'b00, 50, 1'b0, 2000);

        // Random level requests; 11 must hold the present level
        repeat (6) begin
            lvl = 2'($urandom_range(0, 3));
            start = int'(vset_code);
            if (lvl == 2'b11) begin
                req_volt = lvl;
                repeat (50) tick();
                check_eq("rnd_hold_vset", int'(vset_code), start);
                check_eq("rnd_hold_stable", int'(volt_stable), 1);
            end else begin
                tgt = lvl_code(lvl);
                if (tgt == start) begin
                    req_volt = lvl;
                    repeat (20) tick();
                    check_eq("rnd_same_vset", int'(vset_code), tgt);
                    check_eq("rnd_same_stable", int'(volt_stable), 1);
                end else begin
                    ramp_track(lvl, tgt, 1'b0, 3000);
                    check_ramp($sformatf("rnd_%0d_%0d", start, tgt), start, tgt, lvl);
                end
            end
        end
        req_volt = 2'b00;
        if (int'(vset_code) != 50) ramp_track(2'b00, 50, 1'b0, 3000);

        // Watchdog expiry with no pings
        auto_ping = 1'b0;
        repeat (5) tick();
        req_volt = 2'b01;
        n_pulse = 0;
        first_pulse = -1;
        for (int i = 1; i <= WDOG; i++) begin
            tick();
            if (wdog_expired) begin
                n_pulse++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        check_eq("wdog_pulses", n_pulse, 1);
        check_eq("wdog_when", first_pulse, WDOG);
        ramp_track(2'b01, 50, 1'b0, 2000);
        check_ramp("wdog_dn", 90, 50, 2'b00);
        repeat (40) tick();
        check_eq("wdog_mask_vset", int'(vset_code), 50);

        // Ping in the expiry cycle cancels the expiry
        req_volt = 2'b00;
        repeat (3) tick();
        req_volt = 2'b01;
        n_pulse = 0;
        for (int i = 1; i < WDOG; i++) begin
            tick();
            if (wdog_expired) n_pulse++;
        end
        tick();
        ping_main = 1'b1;
        #1;
        check_eq("ping_wins", int'(wdog_expired), 0);
        tick();
        ping_main = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (wdog_expired) n_pulse++;
        end
        check_eq("ping_no_pulse", n_pulse, 0);
        check_eq("ping_vset", int'(vset_code), 90);
        check_eq("ping_cur_volt", int'(cur_volt), 1);
        auto_ping = 1'b1;
        ramp_track(2'b00, 50, 1'b0, 2000);
        check_ramp("ping_dn", 90, 50, 2'b00);

        // Settle check failure
        vbus_ok = 1'b0;
        req_volt = 2'b01;
        k = 0;
        while (!fault && k < 2000) begin
            tick();
            k++;
        end
        check_eq("fault_when", k, 2 + 40 * STEP + SETTLE);
        check_eq("fault_vset", int'(vset_code), 50);
        check_eq("fault_cur_volt", int'(cur_volt), 0);
        check_eq("fault_discharge", int'(discharge), 1);
        req_volt = 2'b10;
        repeat (50) tick();
        check_eq("fault_hold", int'(fault), 1);
        check_eq("fault_hold_vset", int'(vset_code), 50);
        req_volt = 2'b00;
        vbus_ok = 1'b1;
        rfm = 1'b1;
        tick();
        rfm = 1'b0;
        check_eq("fault_clear", int'(fault), 0);
        check_eq("fault_clear_dis", int'(discharge), 0);
        repeat (20) tick();
        check_eq("fault_exit_vset", int'(vset_code), 50);

        // Asynchronous reset in the middle of a ramp
        req_volt = 2'b10;
        wait_code(77, 2000);
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        req_volt = 2'b00;
        repeat (3) tick();
        check_eq("rst_held_vset", int'(vset_code), 50);
        rstn = 1'b1;
        repeat (20) tick();
        check_eq("post_rst_vset", int'(vset_code), 50);
        check_eq("post_rst_stable", int'(volt_stable), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
